// File: rtl/maxpool_rstl_conv_pkg.sv
// Shared defaults for the conv -> pool slice: map geometry, word width,
// derived word counts and address widths, plus the pooling FSM state type.
package maxpool_rstl_conv_pkg;

    localparam int unsigned DEF_DATA_W     = 8;
    localparam int unsigned DEF_IMG_W      = 26;
    localparam int unsigned DEF_IMG_H      = 26;
    localparam int unsigned DEF_MAP_WORDS  = DEF_IMG_W * DEF_IMG_H;
    localparam int unsigned DEF_POOL_WORDS = (DEF_IMG_W / 2) * (DEF_IMG_H / 2);
    localparam int unsigned DEF_RD_ADDR_W  = $clog2(DEF_MAP_WORDS);
    localparam int unsigned DEF_WR_ADDR_W  = $clog2(DEF_POOL_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/maxpool_rstl_conv_pool_addr_gen.sv
// Read-address generator: walks 2x2 windows row-major, 4 reads per window,
// building addresses from incremental row-base/column registers (no multiply).
module maxpool_rstl_conv_pool_addr_gen
    import maxpool_rstl_conv_pkg::*;
#(
    parameter int unsigned IMG_W     = DEF_IMG_W,
    parameter int unsigned IMG_H     = DEF_IMG_H,
    parameter int unsigned RD_ADDR_W = DEF_RD_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    output logic                 rd_en,
    output logic [RD_ADDR_W-1:0] rd_addr,
    output logic [1:0]           k,
    output logic                 last
);

    localparam int unsigned PW = IMG_W / 2;
    localparam int unsigned PH = IMG_H / 2;
    localparam int unsigned CW = $clog2(PW + 1);
    localparam int unsigned RW = $clog2(PH + 1);
    localparam logic [RD_ADDR_W-1:0] LINE     = RD_ADDR_W'(IMG_W);
    localparam logic [RD_ADDR_W-1:0] ROW_STEP = RD_ADDR_W'(2 * IMG_W);

    logic [CW-1:0]        pc_q, pc_d;
    logic [RW-1:0]        pr_q, pr_d;
    logic [1:0]           k_q, k_d;
    logic [RD_ADDR_W-1:0] row_base_q, row_base_d;
    logic [RD_ADDR_W-1:0] col_q, col_d;
    logic [RD_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic                 rd_en_q, rd_en_d;
    logic                 last_rd;

    assign last_rd = rd_en_q && (k_q == 2'd3) && (pc_q == CW'(PW - 1)) && (pr_q == RW'(PH - 1));

    always_comb begin
        pc_d       = pc_q;
        pr_d       = pr_q;
        k_d        = k_q;
        row_base_d = row_base_q;
        col_d      = col_q;
        rd_en_d    = rd_en_q;
        if (load) begin
            pc_d       = '0;
            pr_d       = '0;
            k_d        = '0;
            row_base_d = '0;
            col_d      = '0;
            rd_en_d    = 1'b1;
        end else if (rd_en_q) begin
            if (last_rd) begin
                rd_en_d = 1'b0;
            end else if (k_q == 2'd3) begin
                k_d = '0;
                if (pc_q == CW'(PW - 1)) begin
                    pc_d       = '0;
                    col_d      = '0;
                    pr_d       = pr_q + 1'b1;
                    row_base_d = row_base_q + ROW_STEP;
                end else begin
                    pc_d  = pc_q + 1'b1;
                    col_d = col_q + RD_ADDR_W'(2);
                end
            end else begin
                k_d = k_q + 1'b1;
            end
        end
        // k[1] selects the lower row of the window, k[0] the right column
        rd_addr_d = row_base_d + col_d + (k_d[1] ? LINE : '0)
                  + {{(RD_ADDR_W-1){1'b0}}, k_d[0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= '0;
            pr_q       <= '0;
            k_q        <= '0;
            row_base_q <= '0;
            col_q      <= '0;
            rd_addr_q  <= '0;
            rd_en_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pr_q       <= pr_d;
            k_q        <= k_d;
            row_base_q <= row_base_d;
            col_q      <= col_d;
            rd_addr_q  <= rd_addr_d;
            rd_en_q    <= rd_en_d;
        end
    end

    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign k       = k_q;
    assign last    = last_rd;

endmodule

// File: rtl/maxpool_rstl_conv.sv
// 2x2 stride-2 max pooling over a stored conv result map; emits the pooled
// map as a row-major stream of (address, value) writes.
module maxpool_rstl_conv
    import maxpool_rstl_conv_pkg::*;
#(
    parameter int unsigned IMG_W     = DEF_IMG_W,
    parameter int unsigned IMG_H     = DEF_IMG_H,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned RD_ADDR_W = DEF_RD_ADDR_W,
    parameter int unsigned WR_ADDR_W = DEF_WR_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 rd_en,
    output logic [RD_ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0]    rd_data,
    output logic                 out_valid,
    output logic [WR_ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0]    out_data
);

    state_t               state_q, state_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 tag_valid_q, tag_valid_d;
    logic [1:0]           tag_k_q, tag_k_d;
    logic [DATA_W-1:0]    max_q, max_d;
    logic [DATA_W-1:0]    out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic [WR_ADDR_W-1:0] out_addr_q, out_addr_d;
    logic                 start_accept;
    logic                 last_rd;
    logic [1:0]           ag_k;
    logic [DATA_W-1:0]    sample_max;

    assign start_accept = start && (state_q == ST_IDLE);

    maxpool_rstl_conv_pool_addr_gen #(
        .IMG_W     (IMG_W),
        .IMG_H     (IMG_H),
        .RD_ADDR_W (RD_ADDR_W)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .load    (start_accept),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .k       (ag_k),
        .last    (last_rd)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_READ;
            ST_READ:  if (last_rd) state_d = ST_DRAIN;
            // no reads remain, so the next output pulse is the final window
            ST_DRAIN: if (out_valid_q) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_READ) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);

        tag_valid_d = rd_en;
        tag_k_d     = ag_k;

        sample_max  = ((tag_k_q == 2'd0) || ($signed(rd_data) > $signed(max_q))) ? rd_data : max_q;
        max_d       = max_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        if (tag_valid_q) begin
            max_d = sample_max;
            if (tag_k_q == 2'd3) begin
                out_data_d  = sample_max;
                out_valid_d = 1'b1;
            end
        end

        out_addr_d = out_addr_q;
        if (start_accept) out_addr_d = '0;
        else if (out_valid_q) out_addr_d = out_addr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tag_valid_q <= 1'b0;
            tag_k_q     <= '0;
            max_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tag_valid_q <= tag_valid_d;
            tag_k_q     <= tag_k_d;
            max_q       <= max_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_maxpool_rstl_conv.sv
// Bench for maxpool_rstl_conv: a default 26x26 instance against a window-max
// reference model, and a 4x4 instance against hand-computed sequences.
module tb_maxpool_rstl_conv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start_s = 1'b0;

    logic       busy, done, rd_en, out_valid;
    logic [9:0] rd_addr;
    logic [7:0] rd_data, out_data;
    logic [7:0] out_addr;

    logic       busy_s, done_s, rd_en_s, out_valid_s;
    logic [3:0] rd_addr_s;
    logic [7:0] rd_data_s, out_data_s;
    logic [1:0] out_addr_s;

    int checks = 0;
    int errors = 0;

    logic signed [7:0] mem_big [0:1023];
    logic signed [7:0] mem_s   [0:15];
    logic signed [7:0] model   [0:168];
    int                exp_addr_s [0:15] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
    logic signed [7:0] exp_out_s  [0:3];

    maxpool_rstl_conv #(
        .IMG_W(26), .IMG_H(26), .DATA_W(8), .RD_ADDR_W(10), .WR_ADDR_W(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data)
    );

    maxpool_rstl_conv #(
        .IMG_W(4), .IMG_H(4), .DATA_W(8), .RD_ADDR_W(4), .WR_ADDR_W(2)
    ) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .busy(busy_s), .done(done_s),
        .rd_en(rd_en_s), .rd_addr(rd_addr_s), .rd_data(rd_data_s),
        .out_valid(out_valid_s), .out_addr(out_addr_s), .out_data(out_data_s)
    );

    // 1-cycle read memories; data is X whenever no read was issued
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem_big[rd_addr];
        else       rd_data <= 'x;
        if (rd_en_s) rd_data_s <= mem_s[rd_addr_s];
        else         rd_data_s <= 'x;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic build_model();
        for (int pr = 0; pr < 13; pr++)
            for (int pc = 0; pc < 13; pc++) begin
                logic signed [7:0] m;
                m = mem_big[(2 * pr) * 26 + 2 * pc];
                for (int dr = 0; dr < 2; dr++)
                    for (int dc = 0; dc < 2; dc++)
                        if (mem_big[(2 * pr + dr) * 26 + 2 * pc + dc] > m)
                            m = mem_big[(2 * pr + dr) * 26 + 2 * pc + dc];
                model[pr * 13 + pc] = m;
            end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 676; i++) mem_big[i] = 8'($urandom);
        build_model();
    endtask

    // One full default-size run, checked cycle by cycle. rst_at >= 0 aborts
    // the run with a reset pulse in that cycle.
    task automatic run_big(input bit spam, input int rst_at);
        int nvalid = 0;
        bit have = 0;
        logic signed [7:0] held = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c <= 682; c++) begin
            bit exp_ov;
            int w;
            if (c > 0) @(negedge clk);
            chk("rd_en", rd_en, c < 676);
            if (c < 676) begin
                w = c / 4;
                chk("rd_addr", rd_addr,
                    (2 * (w / 13) + (c % 4) / 2) * 26 + 2 * (w % 13) + (c % 4) % 2);
            end
            exp_ov = (c >= 5) && ((c - 5) % 4 == 0) && ((c - 5) / 4 < 169);
            chk("out_valid", out_valid, exp_ov);
            if ($isunknown(out_data)) begin
                errors++;
                $display("FAIL out_data_x: got X expected known value at cycle %0d", c);
            end
            if (exp_ov) begin
                w = (c - 5) / 4;
                chk("out_data", $signed(out_data), model[w]);
                chk("out_addr", out_addr, w);
                held = model[w];
                have = 1;
            end else if (have) begin
                chk("out_data_hold", $signed(out_data), held);
            end
            chk("busy", busy, c <= 677);
            chk("done", done, c == 678);
            if (out_valid) nvalid++;
            start = (spam && c < 600 && (c % 37 == 3)) ? 1'b1 : 1'b0;
            if (c == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_rd_en", rd_en, 0);
                chk("rst_rd_addr", rd_addr, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_out_valid", out_valid, 0);
                chk("rst_out_addr", out_addr, 0);
                chk("rst_out_data", out_data, 0);
                @(negedge clk);
                chk("rst_idle_busy", busy, 0);
                chk("rst_idle_rd_en", rd_en, 0);
                return;
            end
        end
        start = 1'b0;
        chk("out_valid_count", nvalid, 169);
    endtask

    task automatic run_small(input string tag);
        int naddr = 0, nout = 0, ndone = 0;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clk);
            if (rd_en_s) begin
                if (naddr < 16) chk({tag, "_rd_addr"}, rd_addr_s, exp_addr_s[naddr]);
                naddr++;
            end
            if (out_valid_s) begin
                if (nout < 4) begin
                    chk({tag, "_out_data"}, $signed(out_data_s), exp_out_s[nout]);
                    chk({tag, "_out_addr"}, out_addr_s, nout);
                end
                nout++;
            end
            if (done_s) ndone++;
        end
        chk({tag, "_reads"}, naddr, 16);
        chk({tag, "_outputs"}, nout, 4);
        chk({tag, "_dones"}, ndone, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rd_en", rd_en, 0);
        chk("reset_rd_addr", rd_addr, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_addr", out_addr, 0);
        chk("reset_out_data", out_data, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) mem_s[i] = 8'(i);
        exp_out_s = '{8'sd5, 8'sd7, 8'sd13, 8'sd15};
        run_small("ramp");

        for (int i = 0; i < 16; i++) mem_s[i] = -8'sd128;
        mem_s[9] = -8'sd127;
        exp_out_s = '{-8'sd128, -8'sd128, -8'sd127, -8'sd128};
        run_small("signed");

        for (int i = 0; i < 676; i++) mem_big[i] = -8'sd5;
        mem_big[27]  = 8'sd100;
        mem_big[675] = -8'sd4;
        build_model();
        chk("model_w0", model[0], 100);
        chk("model_w1", model[1], -5);
        chk("model_w168", model[168], -4);
        run_big(0, -1);

        fill_random();
        run_big(1, -1);
        fill_random();
        run_big(0, -1);
        fill_random();
        run_big(0, 300);
        fill_random();
        run_big(0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/maxpool_rstl_conv.md
Name: maxpool_rstl_conv

Overview:
- Downstream consumer of the convolution-result memory: once a full 26x26 feature map has been written, this block reads it back and performs 2x2, stride-2 max pooling.
- It produces a 13x13 pooled map as a stream of (address, value) writes into the pooled-result memory.
- It generates its own read addresses, so the result memory needs only one simple read port with fixed 1-cycle latency.

Parameters:
- IMG_W, 26, width of the conv result map; must be even.
- IMG_H, 26, height of the conv result map; must be even.
- DATA_W, 8, width of each result word (signed two's complement).
- RD_ADDR_W, 10, read address width; 2^RD_ADDR_W >= IMG_W*IMG_H.
- WR_ADDR_W, 8, pooled address width; 2^WR_ADDR_W >= (IMG_W/2)*(IMG_H/2).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset: synchronous, active-high.
- start  in  1  single-cycle request to pool one full map.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last pooled word is emitted.
- rd_en  out  1  read strobe to the conv result memory.
- rd_addr  out  RD_ADDR_W  read address.
- rd_data  in  DATA_W  memory data, valid exactly 1 cycle after rd_en.
- out_valid  out  1  pooled word valid (write strobe to the pooled memory).
- out_addr  out  WR_ADDR_W  pooled write address, row-major, 0..(IMG_W/2)*(IMG_H/2)-1.
- out_data  out  DATA_W  pooled maximum (signed).

Behaviour:
- Reset: FSM goes to IDLE. busy, done, rd_en and out_valid are 0. rd_addr, out_addr, out_data and all counters are 0. Reset has priority over every other input, including mid-operation; any partially computed window is discarded.
- FSM states:
  - IDLE: start=1 moves to READ. start is ignored in every other state.
  - READ: issues one read per cycle, with 4 consecutive reads per window.
  - DRAIN: waits for the final data and the final output register.
  - DONE: one cycle, done=1, then back to IDLE.
- Read order, window (pr,pc), sample k=0..3 at offsets (dr,dc) = (0,0),(0,1),(1,0),(1,1):
  - rd_addr = (2*pr+dr)*IMG_W + 2*pc + dc.
  - Windows are visited row-major: pc fastest, then pr.
  - Addresses are built from incremental row-base and column registers. No multiplier.
- Read timing:
  - First read (rd_addr=0, rd_en=1) is in the cycle after start is accepted; call it cycle 0.
  - rd_en stays high for 4*(IMG_W/2)*(IMG_H/2) consecutive cycles, then drops. With defaults that is 676 cycles, cycles 0..675.
- Datapath:
  - A sample-tag pipeline (valid + k) is delayed 1 cycle to align with rd_data.
  - k=0: load the running max with rd_data.
  - k=1..3: running max = signed max(running max, rd_data). Ties keep the held value (no observable difference).
  - When k=3 data arrives, the final max is registered into out_data, with out_valid=1 for exactly one cycle in the following cycle.
- Window timing: window w reads at cycles 4w..4w+3 and out_valid is high at cycle 4w+5. With defaults the last out_valid is at cycle 677.
- out_addr: 0 at the first out_valid; increments by 1 after each out_valid; is not reset between runs except by the start of a new run, which clears it to 0.
- Completion:
  - DRAIN lasts until the last out_valid cycle.
  - DONE is the next cycle: done=1 and busy=0 in that same cycle. With defaults this is cycle 678.
- out_data holds its last value while out_valid=0.
- busy timing: busy=1 from cycle 0 through the last out_valid cycle.
- No backpressure: the downstream write port must accept one word per cycle.

Decomposition:
- Shared package: DATA_W, the default map dimensions (26, 13) and the derived counts (676, 169) with their address widths, so the conv, position counter and pool stages stay consistent.
- One natural sub-module: pool_addr_gen, holding the pr/pc/k counters, row base and rd_addr/rd_en generation, with a last-read flag output.
- Max compare, output register and FSM stay in the top module.

Test Plan:
- 4x4 map, mem[i]=i, start -> rd_addr sequence 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15; out_data 5,7,13,15 at out_addr 0..3.
- 4x4 map, all words -128 except mem[9]=-127 -> outputs -128,-128,-127,-128; checks the signed compare.
- Default 26x26, random data -> 169 out_valid pulses matching a reference model; first at cycle 5, last at cycle 677, done at cycle 678, rd_en high exactly 676 cycles.
- start pulsed repeatedly while busy -> ignored; exactly 169 outputs and one done; a second start after done runs again with out_addr restarting at 0.
- rst asserted at cycle 300 of a run -> next cycle all outputs 0 and FSM in IDLE; a fresh start gives a complete, correct 169-word map.
- rd_data driven X when the rd_en tag is absent -> out_data never X; checks that sampling is gated by the delayed tag.
